// File: rtl/ram_march_initiator.sv
`default_nettype none
// ============================================================================
// Module   : ram_march_initiator
// Purpose  : Built-in self-test initiator for a single-port ram_simple.
//            Runs a 4-phase march (write PATTERN ascending, read/verify
//            ascending, write ~PATTERN descending, read/verify descending)
//            and counts every mismatching read word.
// Options  : RAM_MARCH_ERR_LOG_EN - adds first_err_addr / first_err_data /
//            first_err_phase capture of the first mismatch after start.
// Revision : 1.0 - initial release
// ============================================================================
module ram_march_initiator #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_MARCH_ERR_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  first_err_phase
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WR0  = 3'd1;
    localparam logic [2:0] c_ST_RD0  = 3'd2;
    localparam logic [2:0] c_ST_WR1  = 3'd3;
    localparam logic [2:0] c_ST_RD1  = 3'd4;
    localparam logic [2:0] c_ST_FIN  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [2:0]            c_LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [15:0]           c_ERR_SAT  = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_draining;   // read phase finished issuing, waiting for RD_LAT returns
    logic [2:0]            r_lat_cnt;
    logic [15:0]           r_err_cnt;
    logic                  r_pass;

    // Read-return pipe: valid flag and phase (0=RD0, 1=RD1) of each issued read.
    // The expected word is derived from the phase bit at the compare point.
    logic [RD_LAT-1:0]     r_vpipe;
    logic [RD_LAT-1:0]     r_ppipe;

    logic                  w_accept;
    logic                  w_addr_max;
    logic                  w_addr_min;
    logic                  w_drain_last;
    logic                  w_issue;
    logic                  w_cmp_valid;
    logic                  w_cmp_phase;
    logic [DATA_WIDTH-1:0] w_expect;
    logic                  w_mismatch;

    assign w_accept     = (r_state == c_ST_IDLE) && start;
    assign w_addr_max   = (r_addr == c_ADDR_MAX);
    assign w_addr_min   = (r_addr == '0);
    assign w_drain_last = r_draining && (r_lat_cnt == c_LAT_LAST);
    assign w_issue      = ((r_state == c_ST_RD0) || (r_state == c_ST_RD1)) && !r_draining;
    assign w_cmp_valid  = r_vpipe[RD_LAT-1];
    assign w_cmp_phase  = r_ppipe[RD_LAT-1];
    assign w_expect     = w_cmp_phase ? ~PATTERN : PATTERN;
    assign w_mismatch   = w_cmp_valid && (ram_rdata != w_expect);

    assign ram_addr = r_addr;
    assign err_cnt  = r_err_cnt;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state: each phase ends on its terminal address (or drain count)
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start)        w_state_nxt = c_ST_WR0;
            c_ST_WR0:  if (w_addr_max)   w_state_nxt = c_ST_RD0;
            c_ST_RD0:  if (w_drain_last) w_state_nxt = c_ST_WR1;
            c_ST_WR1:  if (w_addr_min)   w_state_nxt = c_ST_RD1;
            c_ST_RD1:  if (w_drain_last) w_state_nxt = c_ST_FIN;
            c_ST_FIN:                    w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs: strobes and write data decoded from the current state
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        pass      = r_pass;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (r_state)
            c_ST_WR0: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = PATTERN;
            end
            c_ST_RD0, c_ST_RD1: begin
                busy      = 1'b1;
            end
            c_ST_WR1: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = ~PATTERN;
            end
            c_ST_FIN: begin
                // Final count is already settled: the last compare retires on the edge into FIN.
                done      = 1'b1;
                pass      = (r_err_cnt == 16'd0);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Address sequencer and read-drain counter. Ascending phases wrap from max
    // to 0 and descending phases from 0 to max only on the phase boundary.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_draining <= 1'b0;
            r_lat_cnt  <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_addr <= '0;
                    end
                    r_draining <= 1'b0;
                    r_lat_cnt  <= 3'd0;
                end
                c_ST_WR0: begin
                    r_addr <= r_addr + 1'b1;
                end
                c_ST_RD0: begin
                    if (!r_draining) begin
                        if (w_addr_max) begin
                            r_draining <= 1'b1;
                            r_lat_cnt  <= 3'd0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (w_drain_last) begin
                        r_draining <= 1'b0;
                        r_addr     <= c_ADDR_MAX;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                c_ST_WR1: begin
                    r_addr <= r_addr - 1'b1;
                end
                c_ST_RD1: begin
                    if (!r_draining) begin
                        if (w_addr_min) begin
                            r_draining <= 1'b1;
                            r_lat_cnt  <= 3'd0;
                        end else begin
                            r_addr <= r_addr - 1'b1;
                        end
                    end else if (w_drain_last) begin
                        r_draining <= 1'b0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read-return pipe: a read issued this cycle is compared RD_LAT cycles later
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe <= '0;
            r_ppipe <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            r_ppipe[0] <= (r_state == c_ST_RD1);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_ppipe[i] <= r_ppipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Error counter (saturating) and held pass flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_err_cnt <= 16'd0;
            r_pass    <= 1'b0;
        end else begin
            if (w_mismatch && (r_err_cnt != c_ERR_SAT)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (r_state == c_ST_FIN) begin
                r_pass <= (r_err_cnt == 16'd0);
            end
        end
    end

`ifdef RAM_MARCH_ERR_LOG_EN
    logic [RD_LAT-1:0][ADDR_WIDTH-1:0] r_apipe;
    logic [ADDR_WIDTH-1:0]             r_ferr_addr;
    logic [DATA_WIDTH-1:0]             r_ferr_data;
    logic                              r_ferr_phase;

    assign first_err_addr  = r_ferr_addr;
    assign first_err_data  = r_ferr_data;
    assign first_err_phase = r_ferr_phase;

    // Address of each in-flight read travels alongside the valid pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_apipe <= '0;
        end else begin
            r_apipe[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_apipe[i] <= r_apipe[i-1];
            end
        end
    end

    // First-mismatch capture: a zero count means no earlier mismatch since start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ferr_addr  <= '0;
            r_ferr_data  <= '0;
            r_ferr_phase <= 1'b0;
        end else if (w_accept) begin
            r_ferr_addr  <= '0;
            r_ferr_data  <= '0;
            r_ferr_phase <= 1'b0;
        end else if (w_mismatch && (r_err_cnt == 16'd0)) begin
            r_ferr_addr  <= r_apipe[RD_LAT-1];
            r_ferr_data  <= ram_rdata;
            r_ferr_phase <= w_cmp_phase;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_march_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_march_initiator
// Purpose  : Self-checking bench for ram_march_initiator. Two instances:
//            A (defaults, 256 x 8, RD_LAT=1) and B (16 x 8, RD_LAT=2), each
//            beside a behavioural RAM. A timeline model predicts every output
//            from the cycle index since the accepted start.
//            RAM_MARCH_ERR_LOG_EN enables the first-error capture checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_march_initiator;

    localparam int N_A = 256;
    localparam int L_A = 1;
    localparam int N_B = 16;
    localparam int L_B = 2;
    localparam int DONE_A = 4 * N_A + 2 * L_A + 1;
    localparam int DONE_B = 4 * N_B + 2 * L_B + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    logic        busy_a, done_a, pass_a, we_a;
    logic [15:0] err_a;
    logic [7:0]  addr_a, wdata_a, rdata_a;
    logic        busy_b, done_b, pass_b, we_b;
    logic [15:0] err_b;
    logic [3:0]  addr_b;
    logic [7:0]  wdata_b, rdata_b;
`ifdef RAM_MARCH_ERR_LOG_EN
    logic [7:0]  ferr_addr_a, ferr_data_a;
    logic        ferr_phase_a;
    logic [3:0]  ferr_addr_b;
    logic [7:0]  ferr_data_b;
    logic        ferr_phase_b;
`endif

    ram_march_initiator dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .ram_we(we_a), .ram_addr(addr_a),
        .ram_wdata(wdata_a), .ram_rdata(rdata_a)
`ifdef RAM_MARCH_ERR_LOG_EN
        , .first_err_addr(ferr_addr_a), .first_err_data(ferr_data_a),
        .first_err_phase(ferr_phase_a)
`endif
    );

    ram_march_initiator #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LAT(2), .PATTERN(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .ram_we(we_b), .ram_addr(addr_b),
        .ram_wdata(wdata_b), .ram_rdata(rdata_b)
`ifdef RAM_MARCH_ERR_LOG_EN
        , .first_err_addr(ferr_addr_b), .first_err_data(ferr_data_b),
        .first_err_phase(ferr_phase_b)
`endif
    );

    // ---------------- behavioural RAMs with injectable read faults ----------
    int fault_a = 0;   // 0 clean, 1 data_out[0] stuck at 0, 2 data_out=0 at addr 0x10
    logic [7:0] mem_a [N_A];
    logic [7:0] mem_b [N_B];
    logic [7:0] rd1_b;

    function automatic int fault(input int mode, input int addr, input int d);
        case (mode)
            1:       return d & 32'hFE;
            2:       return (addr == 16) ? 0 : d;
            default: return d;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N_A; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < N_B; i++) mem_b[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= 8'(fault(fault_a, int'(addr_a), int'(mem_a[addr_a])));
        if (we_b) mem_b[addr_b] <= wdata_b;
        rd1_b   <= mem_b[addr_b];
        rdata_b <= rd1_b;
    end

    // ---------------- reference model ----------------------------------------
    typedef struct {
        bit busy;
        bit done;
        bit we;
        int wdata;
        int addr;
        bit addr_known;
    } exp_t;

    // Expected outputs t cycles after the accepted start edge (t=0: idle)
    function automatic exp_t model(input int t, input int n, input int l, input bit fresh);
        exp_t e;
        e = '{busy: 0, done: 0, we: 0, wdata: 0, addr: 0, addr_known: 0};
        if (t == 0) begin
            e.addr_known = fresh;
        end else if (t <= n) begin
            e.busy = 1; e.we = 1; e.wdata = 'hA5; e.addr = t - 1; e.addr_known = 1;
        end else if (t <= 2 * n) begin
            e.busy = 1; e.addr = t - n - 1; e.addr_known = 1;
        end else if (t <= 2 * n + l) begin
            e.busy = 1; e.addr = n - 1; e.addr_known = 1;
        end else if (t <= 3 * n + l) begin
            e.busy = 1; e.we = 1; e.wdata = 'h5A; e.addr = n - 1 - (t - 2 * n - l - 1); e.addr_known = 1;
        end else if (t <= 4 * n + l) begin
            e.busy = 1; e.addr = n - 1 - (t - 3 * n - l - 1); e.addr_known = 1;
        end else if (t <= 4 * n + 2 * l) begin
            e.busy = 1; e.addr = 0; e.addr_known = 1;
        end else begin
            e.done = 1;
        end
        return e;
    endfunction

    function automatic int exp_errs(input int mode, input int n);
        int e = 0;
        for (int a = 0; a < n; a++) begin
            if (fault(mode, a, 'hA5) != 'hA5) e++;
            if (fault(mode, a, 'h5A) != 'h5A) e++;
        end
        return e;
    endfunction

    int  ta = 0, tb_t = 0;
    int  tot_a = 0, tot_b = 0;
    int  xerr_a = 0, xerr_b = 0;
    bit  xpass_a = 0, xpass_b = 0;
    bit  fresh_a = 1, fresh_b = 1;

    // Model timeline advance, sampling the same inputs the DUTs sample
    always @(posedge clk) begin
        if (rst) begin
            ta = 0; tb_t = 0; xerr_a = 0; xerr_b = 0;
            xpass_a = 0; xpass_b = 0; fresh_a = 1; fresh_b = 1;
        end else begin
            if (ta == 0) begin
                if (start_a) begin
                    ta = 1; xerr_a = 0; xpass_a = 0;
                    tot_a = exp_errs(fault_a, N_A);
                end
            end else if (ta == DONE_A) begin
                ta = 0; fresh_a = 0; xerr_a = tot_a; xpass_a = (tot_a == 0);
            end else begin
                ta++;
            end
            if (tb_t == 0) begin
                if (start_b) begin
                    tb_t = 1; xerr_b = 0; xpass_b = 0; tot_b = 0;
                end
            end else if (tb_t == DONE_B) begin
                tb_t = 0; fresh_b = 0; xerr_b = tot_b; xpass_b = (tot_b == 0);
            end else begin
                tb_t++;
            end
        end
    end

    // ---------------- checking -----------------------------------------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        exp_t ea;
        exp_t eb;
        if (chk_en) begin
            ea = model(ta, N_A, L_A, fresh_a);
            chk("a_busy",  32'(busy_a),  32'(ea.busy));
            chk("a_done",  32'(done_a),  32'(ea.done));
            chk("a_we",    32'(we_a),    32'(ea.we));
            chk("a_wdata", 32'(wdata_a), 32'(ea.wdata));
            if (ea.addr_known) chk("a_addr", 32'(addr_a), 32'(ea.addr));
            if (ta == DONE_A) begin
                chk("a_err_fin",  32'(err_a),  32'(tot_a));
                chk("a_pass_fin", 32'(pass_a), 32'(tot_a == 0));
            end else if (ta == 0) begin
                chk("a_err_idle",  32'(err_a),  32'(xerr_a));
                chk("a_pass_idle", 32'(pass_a), 32'(xpass_a));
            end else begin
                chk("a_pass_busy", 32'(pass_a), 32'(0));
                if (ta <= N_A) chk("a_err_wr0", 32'(err_a), 32'(0));
            end

            eb = model(tb_t, N_B, L_B, fresh_b);
            chk("b_busy",  32'(busy_b),  32'(eb.busy));
            chk("b_done",  32'(done_b),  32'(eb.done));
            chk("b_we",    32'(we_b),    32'(eb.we));
            chk("b_wdata", 32'(wdata_b), 32'(eb.wdata));
            if (eb.addr_known) chk("b_addr", 32'(addr_b), 32'(eb.addr));
            if (tb_t == DONE_B) begin
                chk("b_err_fin",  32'(err_b),  32'(tot_b));
                chk("b_pass_fin", 32'(pass_b), 32'(tot_b == 0));
            end else if (tb_t == 0) begin
                chk("b_err_idle",  32'(err_b),  32'(xerr_b));
                chk("b_pass_idle", 32'(pass_b), 32'(xpass_b));
            end
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on DUT A; start is high in cycle 0, optional re-pulse mid-run
    task automatic run_a(input int mode, input int repulse_at,
                         output int cyc, output int n_pat, output int n_inv,
                         output int n_done, output bit pass_at_done, output int err_at_done);
        bit found = 0;
        fault_a = mode;
        cyc = 0; n_pat = 0; n_inv = 0; n_done = 0; pass_at_done = 0; err_at_done = -1;
        start_a = 1'b1;
        while (!found && cyc < 3000) begin
            tick();
            cyc++;
            start_a = (cyc == repulse_at);
            if (we_a && wdata_a == 8'hA5) n_pat++;
            if (we_a && wdata_a == 8'h5A) n_inv++;
            if (done_a) begin
                found = 1;
                n_done++;
                pass_at_done = pass_a;
                err_at_done = int'(err_a);
            end
        end
        chk("a_done_seen", 32'(found), 32'(1));
        // start during the done cycle must not be accepted
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_fin_start_ignored", 32'(busy_a), 32'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a) n_done++;
        end
    endtask

    int  cyc, n_pat, n_inv, n_done, err_done;
    bit  pass_done;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1;
        chk("rst_busy", 32'(busy_a), 32'(0));
        chk("rst_err",  32'(err_a),  32'(0));
        chk("rst_addr", 32'(addr_a), 32'(0));
`ifdef RAM_MARCH_ERR_LOG_EN
        chk("rst_ferr_addr", 32'(ferr_addr_a), 32'(0));
`endif
        rst = 1'b0;
        tick();

        // clean RAM
        run_a(0, -1, cyc, n_pat, n_inv, n_done, pass_done, err_done);
        chk("clean_done_cycle", 32'(cyc),       32'(1027));
        chk("clean_we_pattern", 32'(n_pat),     32'(256));
        chk("clean_we_inverse", 32'(n_inv),     32'(256));
        chk("clean_pass",       32'(pass_done), 32'(1));
        chk("clean_err",        32'(err_done),  32'(0));
        chk("clean_one_done",   32'(n_done),    32'(1));

        // stuck-at-0 on data_out[0]
        run_a(1, -1, cyc, n_pat, n_inv, n_done, pass_done, err_done);
        chk("stuck_err",  32'(err_done),  32'(256));
        chk("stuck_pass", 32'(pass_done), 32'(0));
        chk("stuck_pass_held", 32'(pass_a), 32'(0));

        // single bad word at address 0x10
        run_a(2, -1, cyc, n_pat, n_inv, n_done, pass_done, err_done);
        chk("addr10_err", 32'(err_done), 32'(2));
`ifdef RAM_MARCH_ERR_LOG_EN
        chk("addr10_ferr_addr",  32'(ferr_addr_a),  32'(8'h10));
        chk("addr10_ferr_data",  32'(ferr_data_a),  32'(8'h00));
        chk("addr10_ferr_phase", 32'(ferr_phase_a), 32'(0));
`endif

        // reset mid-test, restart ten cycles later
        fault_a = 0;
        n_done = 0;
        start_a = 1'b1;
        cyc = 0;
        while (cyc < 300) begin
            tick(); cyc++; start_a = 1'b0;
            if (done_a) n_done++;
        end
        rst = 1'b1;
        tick(); cyc++;
        rst = 1'b0;
        chk("rstmid_busy",  32'(busy_a),  32'(0));
        chk("rstmid_done",  32'(done_a),  32'(0));
        chk("rstmid_pass",  32'(pass_a),  32'(0));
        chk("rstmid_err",   32'(err_a),   32'(0));
        chk("rstmid_we",    32'(we_a),    32'(0));
        chk("rstmid_addr",  32'(addr_a),  32'(0));
        chk("rstmid_wdata", 32'(wdata_a), 32'(0));
        while (cyc < 310) begin
            tick(); cyc++;
            if (done_a) n_done++;
        end
        chk("rstmid_no_done_before_restart", 32'(n_done), 32'(0));
        run_a(0, -1, cyc, n_pat, n_inv, n_done, pass_done, err_done);
        chk("rstmid_done_cycle", 32'(cyc),      32'(1027));
        chk("rstmid_err_done",   32'(err_done), 32'(0));

        // start re-pulsed while busy
        run_a(0, 500, cyc, n_pat, n_inv, n_done, pass_done, err_done);
        chk("repulse_done_cycle", 32'(cyc),    32'(1027));
        chk("repulse_one_done",   32'(n_done), 32'(1));

        // DUT B: 16 words, two-cycle read latency
        start_b = 1'b1;
        cyc = 0;
        pass_done = 0;
        begin
            bit found_b = 0;
            while (!found_b && cyc < 200) begin
                tick(); cyc++; start_b = 1'b0;
                if (done_b) begin
                    found_b = 1;
                    pass_done = pass_b;
                end
            end
            chk("b_done_seen", 32'(found_b), 32'(1));
        end
        chk("b_done_cycle", 32'(cyc),       32'(69));
        chk("b_pass",       32'(pass_done), 32'(1));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
